axi_lite_regs: RTL
==================

Name: axi_lite_regs

Overview:
- AXI4-Lite slave register bank that terminates the shared slave port of the two-master AXI4-Lite interconnect.
- Holds N_CTRL read/write control registers that drive fabric logic, and exposes N_STAT read-only status words sampled from fabric inputs.
- Supports one outstanding transaction at a time, which matches the upstream arbiter's single-transaction grant.

Parameters:
- AW, 32, AXI address width.
- DW, 32, AXI data width; only 32 is supported.
- N_CTRL, 4, number of RW control registers, 1..16.
- N_STAT, 4, number of RO status registers, 1..16.
- CTRL_RST, 0, reset value of every control register, DW bits.

Ports:
- aclk  in  1  clock.
- areset  in  1  reset: synchronous, active-high, single clock domain (aclk).
- s  axi4_lite_if.s  AW/DW  AXI4-Lite slave. The block drives awready, wready, bvalid, bresp[1:0], arready, rvalid, rdata[DW-1:0], rresp[1:0].
- ctrl_o  out  N_CTRL*DW  control registers; register k sits at bits [k*DW +: DW].
- wr_pulse_o  out  N_CTRL  1-cycle strobe on the cycle after register k is written.
- stat_i  in  N_STAT*DW  status words; word j sits at bits [j*DW +: DW].

Behaviour:
- Decode:
  - index = addr[2 +: IW], where IW = clog2(N_CTRL+N_STAT).
  - addr[1:0] and bits above 2+IW are ignored; the upstream block owns base decode.
  - awprot and arprot are ignored.
  - Index 0..N_CTRL-1 selects ctrl[k]. Index N_CTRL..N_CTRL+N_STAT-1 selects stat[index-N_CTRL].
- Responses:
  - OKAY = 2'b00. SLVERR = 2'b10.
  - Read of an index >= N_CTRL+N_STAT: SLVERR, rdata = 0.
  - Write to a status index or an out-of-range index: SLVERR, no register change, no pulse.
- States: IDLE, WR_RESP, RD_DATA. Internal flags aw_got and w_got capture awaddr and wdata/wstrb.
- IDLE ready rules:
  - arready = !aw_got && !w_got.
  - awready = !aw_got && !(arvalid && arready).
  - wready = !w_got && !(arvalid && arready).
  - A read therefore wins over a write when both arrive in the same cycle with nothing captured.
- Read path:
  - On the AR handshake (cycle N), latch the decoded read data; status is sampled at this edge. Move to RD_DATA.
  - rvalid = 1 from N+1. rdata and rresp stay stable while rvalid && !rready.
  - The rvalid && rready handshake returns to IDLE; arready may be 1 on the next cycle.
- Write path:
  - AW and W may handshake in the same cycle or in either order across cycles; each is captured once.
  - At the edge where both are held (captured, or handshaking that cycle), the byte-lane write is applied: byte b of ctrl[k] is updated only if wstrb[b] = 1.
  - At that same edge wr_pulse_o[k] = 1 for exactly one cycle (only when wstrb != 0 and the response is OKAY), bvalid = 1, flags clear, and state moves to WR_RESP.
  - wstrb = 0 gives an OKAY response with no change and no pulse.
  - bvalid and bresp are held until bready; then return to IDLE.
- In RD_DATA and WR_RESP: arready = awready = wready = 0.
- Throughput: at most one transaction per 2 cycles.
- Reset (areset = 1 at a clock edge, in any state including mid-transaction):
  - ctrl_o = CTRL_RST, wr_pulse_o = 0, all readies = 0, bvalid = rvalid = 0, bresp = rresp = 0, rdata = 0.
  - Pending flags and the response are discarded. State returns to IDLE on the first cycle after reset deasserts.
- The block is fully synchronous, with no combinational path from stat_i to rdata.

Test Plan:
- Reset: assert areset for 3 cycles mid-write (AW captured) -> ctrl_o = 0, bvalid = 0; after release, write 0x8 = 0x5 with strb F -> accepted normally, ctrl[2] = 0x5.
- Full write: AW and W together, addr 0x4, data 0xDEADBEEF, strb 4'hF -> bvalid on the next cycle with bresp 00, ctrl[1] = 0xDEADBEEF, wr_pulse_o = 4'b0010 for 1 cycle. Then addr 0x4, data 0x11223344, strb 4'b0101 -> ctrl[1] = 0xDE22BE44.
- Split write with backpressure: AW at cycle 0, W at cycle 3, bready low for 5 cycles -> bvalid rises at cycle 4 and stays high with bresp stable; awready = wready = 0 until the B handshake.
- Status read: stat[1] = 0xCAFE0001, read addr 0x14, rready low for 2 cycles while stat[1] changes to 0x0 -> rdata = 0xCAFE0001 held, rresp 00.
- Errors (N_STAT = 3): read addr 0x1C -> rresp 10, rdata 0. Write 0x10 = 0xFFFFFFFF -> bresp 10, ctrl unchanged, no pulse.
- Collision: arvalid for addr 0x0 and awvalid+wvalid for addr 0x0 = 0x77 in the same IDLE cycle -> the read completes first returning the old value, then the write is accepted and ctrl[0] = 0x77.

Source files
------------

// File: rtl/axi_lite_regs_if.sv
// AXI4-Lite bus bundle shared by the interconnect masters and the register bank slave.
interface axi4_lite_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport s (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport m (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regs.sv
// AXI4-Lite register bank: N_CTRL byte-writable control words followed by N_STAT
// read-only status words, one outstanding transaction at a time.
module axi_lite_regs #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            N_CTRL   = 4,
  parameter int            N_STAT   = 4,
  parameter logic [DW-1:0] CTRL_RST = '0
) (
  input  logic                 aclk,
  input  logic                 areset,
  axi4_lite_if.s               s,
  output logic [N_CTRL*DW-1:0] ctrl_o,
  output logic [N_CTRL-1:0]    wr_pulse_o,
  input  logic [N_STAT*DW-1:0] stat_i
);

  localparam int IW = $clog2(N_CTRL + N_STAT);
  localparam int SW = DW / 8;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_RESP, RD_DATA} state_t;

  state_t          state;
  logic            aw_got;
  logic            w_got;
  logic [IW-1:0]   aw_idx_q;
  logic [DW-1:0]   wdata_q;
  logic [SW-1:0]   wstrb_q;
  logic [DW-1:0]   ctrl_q [N_CTRL];
  logic            bvalid_q;
  logic [1:0]      bresp_q;
  logic            rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;

  logic            is_idle;
  logic            ar_hs;
  logic            aw_hs;
  logic            w_hs;
  logic            wr_go;
  logic [IW-1:0]   rd_idx;
  logic [IW-1:0]   wr_idx;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_strb;
  logic [DW-1:0]   rd_data;
  logic            rd_err;
  logic            wr_err;

  logic [AW-1:0]   unused_awaddr;
  logic [AW-1:0]   unused_araddr;
  logic [5:0]      unused_prot;

  // Only the index field of each address matters; base decode lives upstream.
  assign unused_awaddr = s.awaddr;
  assign unused_araddr = s.araddr;
  assign unused_prot   = {s.awprot, s.arprot};

  // Readies stay low while reset is held so nothing is accepted into a clearing bank.
  assign is_idle   = (state == IDLE) && !areset;
  assign s.arready = is_idle && !aw_got && !w_got;
  assign ar_hs     = s.arvalid && s.arready;
  assign s.awready = is_idle && !aw_got && !ar_hs;
  assign s.wready  = is_idle && !w_got && !ar_hs;
  assign aw_hs     = s.awvalid && s.awready;
  assign w_hs      = s.wvalid && s.wready;
  assign wr_go     = (aw_got || aw_hs) && (w_got || w_hs);

  assign rd_idx  = s.araddr[2 +: IW];
  assign wr_idx  = aw_got ? aw_idx_q : s.awaddr[2 +: IW];
  assign wr_data = w_got ? wdata_q : s.wdata;
  assign wr_strb = w_got ? wstrb_q : s.wstrb;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b1;
    for (int k = 0; k < N_CTRL; k++) begin
      if (int'(rd_idx) == k) begin
        rd_data = ctrl_q[k];
        rd_err  = 1'b0;
      end
    end
    for (int j = 0; j < N_STAT; j++) begin
      if (int'(rd_idx) == N_CTRL + j) begin
        rd_data = stat_i[j*DW +: DW];
        rd_err  = 1'b0;
      end
    end
    wr_err = (int'(wr_idx) >= N_CTRL);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_idx_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      wr_pulse_o <= '0;
      for (int k = 0; k < N_CTRL; k++) ctrl_q[k] <= CTRL_RST;
    end else begin
      wr_pulse_o <= '0;
      case (state)
        IDLE: begin
          if (ar_hs) begin
            rdata_q  <= rd_data;
            rresp_q  <= rd_err ? SLVERR : OKAY;
            rvalid_q <= 1'b1;
            state    <= RD_DATA;
          end else if (wr_go) begin
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_err ? SLVERR : OKAY;
            state    <= WR_RESP;
            for (int k = 0; k < N_CTRL; k++) begin
              if (!wr_err && int'(wr_idx) == k) begin
                for (int b = 0; b < SW; b++) begin
                  if (wr_strb[b]) ctrl_q[k][8*b +: 8] <= wr_data[8*b +: 8];
                end
                wr_pulse_o[k] <= |wr_strb;
              end
            end
          end else begin
            // Hold whichever half of the write arrived first until its partner shows up.
            if (aw_hs) begin
              aw_got   <= 1'b1;
              aw_idx_q <= s.awaddr[2 +: IW];
            end
            if (w_hs) begin
              w_got   <= 1'b1;
              wdata_q <= s.wdata;
              wstrb_q <= s.wstrb;
            end
          end
        end
        WR_RESP: begin
          if (s.bready) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        RD_DATA: begin
          if (s.rready) begin
            rvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.bvalid = bvalid_q;
  assign s.bresp  = bresp_q;
  assign s.rvalid = rvalid_q;
  assign s.rresp  = rresp_q;
  assign s.rdata  = rdata_q;

  for (genvar k = 0; k < N_CTRL; k++) begin : g_ctrl
    assign ctrl_o[k*DW +: DW] = ctrl_q[k];
  end

endmodule
